// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum accumulator block.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int SUM_W_DEF = 5;
  localparam int ACC_W_DEF = 8;
  localparam int COUNT_DEF = 4;

  // Sample counter width; a single-sample frame still needs a 1-bit counter.
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/acc_add.sv
// Combinational W-bit ripple-carry adder with carry-out, one full adder per bit.
module acc_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = c[W];

endmodule

// File: rtl/sum_accumulator.sv
// Totals a frame of COUNT adder results; wraps on overflow, or saturates when
// SUM_ACC_SATURATE_EN is defined. out_ovf is sticky for the frame.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int COUNT = COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             busy,
  output state_t           state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and data is held while valid && !ready.

  localparam int CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  assign sum_ext = ACC_W'(in_sum);

  acc_add #(.W(ACC_W)) u_acc_add (
    .a_i    (acc_q),
    .b_i    (sum_ext),
    .sum_o  (add_sum),
    .carry_o(add_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | add_carry;
`ifdef SUM_ACC_SATURATE_EN
          // Once saturated the total is pinned for the remainder of the frame.
          acc_d = (ovf_q || add_carry) ? '1 : add_sum;
`else
          acc_d = add_sum;
`endif
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A start seen here is dropped; a new frame needs start while idle.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_total = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule
